// File: rtl/nibble_alu_sequencer_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer: state encoding,
// default slice width and the step-counter sizing helper.
package nibble_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_DEF = 4;

  // Width of a counter that indexes width/nibble slices; never narrower than one bit.
  function automatic int step_w(input int width, input int nibble);
    int n;
    n = width / nibble;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_alu_sequencer_adder.sv
// Combinational NIBBLE-bit ripple-carry adder slice; zero latency, no flow control.
module nibble_adder #(
  parameter int NIBBLE = 4
) (
  input  logic [NIBBLE-1:0] i_a,
  input  logic [NIBBLE-1:0] i_b,
  input  logic              i_ci,
  output logic [NIBBLE-1:0] o_sum,
  output logic              o_co
);

  logic [NIBBLE:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_ci;
    for (int i = 0; i < NIBBLE; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_co = w_c[NIBBLE];

endmodule

// File: rtl/nibble_alu_sequencer.sv
// Nibble-serial WIDTH-bit add/subtract: one adder slice per clock, LSB first.
// Request edge to o_rdy takes WIDTH/NIBBLE edges; requests while busy are dropped and flagged.
module nibble_alu_sequencer
  import nibble_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NIBBLE = NIBBLE_DEF
) (
  input  logic             i_clk_in,
  input  logic             i_rst_n,
  input  logic             i_data_rdy,
  input  logic             i_substract_signal,
  input  logic [WIDTH-1:0] i_r1,
  input  logic [WIDTH-1:0] i_r2,
  output logic             o_busy,
  output logic             o_rdy,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_overrun,
  output logic [7:0]       o_debug_led
);

  localparam int NSTEP = WIDTH / NIBBLE;
  localparam int SW    = step_w(WIDTH, NIBBLE);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SW-1:0]    r_step;
  logic             r_carry;
  logic             r_d_q;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_overrun;

  logic             w_req;
  logic             w_accept;
  logic             w_last;
  logic             w_busy;
  logic             w_rdy;
  int unsigned      w_base;
  logic [NIBBLE-1:0] w_a_sl;
  logic [NIBBLE-1:0] w_b_sl;
  logic [NIBBLE-1:0] w_slice_sum;
  logic             w_slice_co;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             w_ovf_nxt;

  assign w_req  = i_data_rdy & ~r_d_q;
  assign w_last = (r_step == SW'(NSTEP - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy      = 1'b0;
    w_rdy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_busy      = 1'b1;
        w_rdy       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Slice operands are muxed out of the latched words; the carry register links slices.
  always_comb begin
    w_base    = int'(r_step) * NIBBLE;
    w_a_sl    = r_a[w_base +: NIBBLE];
    w_b_sl    = r_b[w_base +: NIBBLE];
    w_sum_nxt = r_sum;
    w_sum_nxt[w_base +: NIBBLE] = w_slice_sum;
    w_ovf_nxt = (r_a[WIDTH-1] == r_b[WIDTH-1]) & (w_sum_nxt[WIDTH-1] != r_a[WIDTH-1]);
  end

  nibble_adder #(
    .NIBBLE(NIBBLE)
  ) u_adder (
    .i_a  (w_a_sl),
    .i_b  (w_b_sl),
    .i_ci (r_carry),
    .o_sum(w_slice_sum),
    .o_co (w_slice_co)
  );

  always_ff @(posedge i_clk_in or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_carry   <= 1'b0;
      r_d_q     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_d_q   <= i_data_rdy;
      if (w_accept) begin
        r_a       <= i_r1;
        r_b       <= i_r2 ^ {WIDTH{i_substract_signal}};
        r_carry   <= i_substract_signal;
        r_step    <= '0;
        r_sum     <= '0;
        r_cout    <= 1'b0;
        r_ovf     <= 1'b0;
        r_zero    <= 1'b0;
        r_overrun <= 1'b0;
      end else begin
        // Any request edge outside IDLE (including the DONE cycle) is dropped.
        if (w_req && (r_state != IDLE)) r_overrun <= 1'b1;
        if (r_state == CALC) begin
          r_sum   <= w_sum_nxt;
          r_carry <= w_slice_co;
          r_step  <= r_step + 1'b1;
          if (w_last) begin
            r_cout <= w_slice_co;
            r_ovf  <= w_ovf_nxt;
            r_zero <= (w_sum_nxt == '0);
          end
        end
      end
    end
  end

  assign o_busy      = w_busy;
  assign o_rdy       = w_rdy;
  assign o_sum       = r_sum;
  assign o_cout      = r_cout;
  assign o_ovf       = r_ovf;
  assign o_zero      = r_zero;
  assign o_overrun   = r_overrun;
  assign o_debug_led = {w_busy, r_overrun, r_cout, r_zero, r_sum[3:0]};

endmodule
